// File: rtl/toggle_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : toggle_rr_scheduler
// Brief    : Round-robin shared toggle flip-flop bank with error flag and a
//            saturating toggle counter. Optional macro: TOGGLE_SYNC_CLR_EN.
// Revision : 1.0  initial release
// ============================================================================
module toggle_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int IDXW  = 3,
    parameter int CNTW  = 16,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef TOGGLE_SYNC_CLR_EN
    input  logic                 clr,
`endif
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NBITS-1:0]     q,
    output logic [IDW-1:0]       grant_id,
    output logic                 grant_vld,
    output logic                 idx_err,
    output logic [CNTW-1:0]      toggle_cnt
);

    localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NBITS-1:0] bank_q, bank_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic             gvld_q, gvld_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             w_win_found;
    logic [IDW-1:0]   w_win_id;
    logic [IDXW-1:0]  w_win_idx;
    logic             w_in_range;
    logic             w_block;
    logic             w_hs;
    int               w_cand;

`ifdef TOGGLE_SYNC_CLR_EN
    assign w_block = rst | clr;
`else
    assign w_block = rst;
`endif

    // Walk offsets from farthest to nearest so the closest valid requester
    // after the pointer is the last (winning) assignment.
    always_comb begin
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_cand      = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            w_cand = (int'(ptr_q) + off) % NREQ;
            if (req_valid[w_cand]) begin
                w_win_found = 1'b1;
                w_win_id    = IDW'(w_cand);
            end
        end
    end

    assign w_win_idx  = req_idx[int'(w_win_id)*IDXW +: IDXW];
    assign w_in_range = (int'(w_win_idx) < NBITS);
    assign w_hs       = w_win_found & ~w_block;
    assign req_ready  = w_hs ? (NREQ'(1) << w_win_id) : '0;

    always_comb begin
        ptr_d  = ptr_q;
        bank_d = bank_q;
        gid_d  = gid_q;
        gvld_d = 1'b0;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (w_hs) begin
            ptr_d  = (w_win_id == c_last_id) ? '0 : w_win_id + IDW'(1);
            gid_d  = w_win_id;
            gvld_d = 1'b1;
            if (w_in_range) begin
                for (int b = 0; b < NBITS; b++) begin
                    if (int'(w_win_idx) == b) begin
                        bank_d[b] = ~bank_q[b];
                    end
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end else begin
                err_d = 1'b1;
            end
        end
`ifdef TOGGLE_SYNC_CLR_EN
        if (clr) begin
            bank_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            bank_q <= '0;
            gid_q  <= '0;
            gvld_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            bank_q <= bank_d;
            gid_q  <= gid_d;
            gvld_q <= gvld_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q          = bank_q;
    assign grant_id   = gid_q;
    assign grant_vld  = gvld_q;
    assign idx_err    = err_q;
    assign toggle_cnt = cnt_q;

endmodule
`default_nettype wire
